// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that adds one nibble per clock through a carry register,
// with valid/ready handshakes on both sides. Define NIBBLE_SERIAL_ADDER_OVF_EN to add the ovf output.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               cout_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W+1:0]   nib_base_s;
  logic [3:0]         a_nib_s;
  logic [3:0]         b_nib_s;
  logic [4:0]         nib_sum_s;
  logic               accept_s;

  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

  // Signed overflow of the top nibble: operands agree in sign but the result does not.
  function automatic logic nib_ovf(input logic [3:0] x, input logic [3:0] y,
                                   input logic [3:0] s);
    return (x[3] ~^ y[3]) & (s[3] ^ x[3]);
  endfunction

  assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s = in_valid && in_ready;

  // Select the current operand nibbles and add them with the rippled carry.
  always_comb begin
    nib_base_s = {idx_r, 2'b00};
    a_nib_s    = 4'(a_r >> nib_base_s);
    b_nib_s    = 4'(b_r >> nib_base_s);
    nib_sum_s  = nib_add(a_nib_s, b_nib_s, carry_r);
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Overflow flag, latched together with cout on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (!accept_s && (state_r == RUN) && (idx_r == LAST_IDX)) begin
      ovf_r <= nib_ovf(a_nib_s, b_nib_s, nib_sum_s[3:0]);
    end
  end

  assign ovf = ovf_r;
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      // Accepting from IDLE or directly from DONE; the latter retires the old result.
      a_r         <= a;
      b_r         <= b;
      carry_r     <= cin;
      sum_r       <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b1;
      state_r     <= RUN;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        RUN: begin
          sum_r[nib_base_s +: 4] <= nib_sum_s[3:0];
          carry_r                <= nib_sum_s[4];
          idx_r                  <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            cout_r      <= nib_sum_s[4];
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign sum       = sum_r;
  assign cout      = cout_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed and random adds against
// a plain-arithmetic reference (a+b+cin), plus handshake, backpressure and reset cases.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands and wait (bounded) for acceptance; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc);
    int n;
    @(negedge clk);
    a = ta; b = tb2; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
  endtask

  // Wait for the result, check latency and value against a+b+cin, then complete the handshake.
  task automatic finish_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                           input string tag);
    int n;
    logic [16:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = {1'b0, ta} + {1'b0, tb2} + 17'(tc);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(e[15:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[16]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'((ta[15] == tb2[15]) && (e[15] != ta[15])));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                    input string tag);
    start_op(ta, tb2, tc);
    finish_op(ta, tb2, tc, tag);
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Directed adds
    op(16'h1234, 16'h4321, 1'b0, "basic");
    op(16'hFFFF, 16'h0001, 1'b0, "wrap");
    op(16'hFFFF, 16'hFFFF, 1'b1, "ripple");
    op(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    op(16'h8000, 16'h8000, 1'b0, "ovf_neg");
    op(16'h0003, 16'h0004, 1'b0, "no_ovf");

    // Backpressure: result held 10 cycles, new request refused until out_ready
    out_ready = 1'b0;
    start_op(16'h0F0F, 16'h0101, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    a = 16'h0202; b = 16'h0303; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h1010);
      check("bp_hold_cout", 32'(cout), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_busy_next", 32'(busy), 32'd1);
    finish_op(16'h0202, 16'h0303, 1'b0, "bp_next");

    // Back-to-back with in_valid held high
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    check("b2b_first", 32'(sum), 32'h0002);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_no_idle", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    check("b2b_second", 32'(sum), 32'h0100);
    check("b2b_spacing", 32'(t2 - t1), 32'd5);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    start_op(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    op(16'h0010, 16'h0020, 1'b0, "post_rst");

    // Random operands
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      op(ra, rb, rc, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
